uart_cmd_ctrl: RTL and testbench
================================

# uart_cmd_ctrl

Parses the ASCII monitor command stream from the UART receiver and sequences the monitor memory logic. It drives the single-cycle strobes for address set, data write, dump start/end/stop, trash and step, plus the shared 32-bit `uart_data` operand. It sits between the UART RX byte interface and the monitor memory/dump logic. The monitor memory/dump logic never sees raw characters.

## Interface
- No parameters.
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous active-low reset.
- `rx_data` in 8: received byte, valid with `rx_valid`.
- `rx_valid` in 1: one-cycle pulse per received byte.
- `dump_running` in 1: memory dump in progress.
- `trush_running` in 1: memory clear in progress.
- `uart_data` out 32: operand register.
- `write_address_set`, `write_data_en`, `inst_address_set`, `inst_data_en` out 1 each: strobes.
- `read_start_set`, `read_end_set`, `read_stop` out 1 each: strobes.
- `pgm_start_set`, `pgm_end_set`, `pgm_stop` out 1 each: strobes.
- `cpu_start`, `quit_cmd`, `start_step`, `start_trush` out 1 each: strobes.
- `cmd_error` out 1: strobe, unrecognised character.
- `echo_data` out 8: echoed byte.
- `echo_valid` out 1: echo strobe.

## Operation
- Character classes:
  - hex digit: 0-9, a-f, A-F
  - delimiter: space 0x20
  - terminator: CR 0x0D or LF 0x0A
  - command letters: w i r p g q s t (lower case only)
  - anything else is invalid.
- Accumulator `acc[31:0]`: on a hex digit, `acc <= {acc[27:0], nibble}`. Overflow drops the high digits. Flag `has_dig` is set.
- Field close: a delimiter or terminator with `has_dig=1` does three things:
  - `uart_data <= acc`
  - assert the field strobe
  - clear `acc` and `has_dig`.
- Empty fields (repeated delimiters, or a terminator with no digits) produce no strobe.
- States: IDLE, CMD, ARG1, ARG2, DATA, SKIP. Register `cmd[2:0]` holds the current letter.
- IDLE:
  - letter s: pulse `start_step`, go to SKIP.
  - letter t: pulse `start_trush`, go to SKIP.
  - letter q: pulse `quit_cmd`. If `dump_running`, also pulse `read_stop` or `pgm_stop`, per the type of the last dump started. Go to SKIP.
  - letters w i r p g: latch `cmd`, go to ARG1.
  - terminator or delimiter: stay in IDLE.
  - hex digit or invalid: pulse `cmd_error`, go to SKIP.
- ARG1 field close:
  - w: `write_address_set`, go to DATA.
  - i: `inst_address_set`, go to DATA.
  - r: `read_start_set`, go to ARG2.
  - p: `pgm_start_set`, go to ARG2.
  - g: `cpu_start`, go to SKIP.
- ARG2 field close:
  - r: `read_end_set`, then SKIP.
  - p: `pgm_end_set`, then SKIP.
  - Records the dump type for a later q.
- DATA field close: `write_data_en` (w) or `inst_data_en` (i). Stay in DATA.
- Terminator in ARG1, ARG2 or DATA: close any pending field, then go to IDLE. A terminator in ARG2 with no digits drops the end set.
- Invalid character in ARG1, ARG2 or DATA: pulse `cmd_error`, discard `acc`, go to SKIP.
- SKIP: discard all bytes until a terminator, then go to IDLE.
- Busy lock: while `dump_running|trush_running`, every byte except q is dropped. Dropped bytes change no state and are not echoed. q is processed as in IDLE from any state; the FSM then goes to SKIP.

## Timing
- All outputs are registered.
- Strobes are high for exactly one cycle, the cycle after the `rx_valid` cycle of the triggering byte.
- `uart_data` updates on that same edge and holds until the next field close.
- Back-to-back `rx_valid` on consecutive cycles must be supported; each byte yields at most one strobe.
- At most one strobe is asserted in any cycle, except q during a dump: `quit_cmd` and `read_stop`/`pgm_stop` are asserted together.
- Reset: state IDLE, `acc=0`, `uart_data=0`, all strobes 0, `echo_data=0`, `echo_valid=0`, dump type = read.
- Reset asserted mid-command returns to IDLE immediately. No strobe is issued.

## Configuration
- `UART_CMD_ECHO_EN` defined: every accepted (non-dropped) byte appears on `echo_data` with `echo_valid` high, one cycle after `rx_valid`.
- `UART_CMD_ECHO_EN` undefined: `echo_data=0` and `echo_valid=0` permanently. The ports remain present.

## Test plan
- Send "w 100 DEADBEEF 1234\r":
  - `write_address_set` with `uart_data=0x100`
  - then `write_data_en` with 0xDEADBEEF
  - then `write_data_en` with 0x00001234
  - FSM ends in IDLE.
- Send "r 0 3c\r": `read_start_set` with 0, then `read_end_set` with 0x3C. Raise `dump_running`, send "x", then "q": "x" is ignored; "q" gives `quit_cmd` and `read_stop` in the same cycle.
- Send "p 0  40\n": the double space gives no extra strobe; result is `pgm_start_set` with 0, then `pgm_end_set` with 0x40. A later q during a dump gives `pgm_stop`.
- Send "g 123456789\r": overflow drops the leading 1; `cpu_start` with `uart_data=0x23456789`.
- Send "z 5\r", then "s\r": `cmd_error` once and no other strobe for the first line; then `start_step` once. Both `rx_valid` streams back-to-back.
- Send "w 10" and assert `rst_n` low before the terminator: no `write_address_set` and `uart_data=0`. With `UART_CMD_ECHO_EN` defined, "t" is echoed with `echo_data=0x74` one cycle after `rx_valid`.

Source files
------------

// File: rtl/uart_cmd_ctrl.sv
// uart_cmd_ctrl: parses ASCII monitor commands from the UART RX byte stream into memory/dump strobes and a 32-bit operand.
// Define UART_CMD_ECHO_EN to echo every accepted byte on echo_data/echo_valid.
module uart_cmd_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        dump_running,
  input  logic        trush_running,
  output logic [31:0] uart_data,
  output logic        write_address_set,
  output logic        write_data_en,
  output logic        inst_address_set,
  output logic        inst_data_en,
  output logic        read_start_set,
  output logic        read_end_set,
  output logic        read_stop,
  output logic        pgm_start_set,
  output logic        pgm_end_set,
  output logic        pgm_stop,
  output logic        cpu_start,
  output logic        quit_cmd,
  output logic        start_step,
  output logic        start_trush,
  output logic        cmd_error,
  output logic [7:0]  echo_data,
  output logic        echo_valid
);
  typedef enum logic [2:0] {IDLE, CMD, ARG1, ARG2, DATA, SKIP} state_t;
  localparam logic [2:0] C_W = 3'd0, C_I = 3'd1, C_R = 3'd2, C_P = 3'd3, C_G = 3'd4;
  localparam logic [3:0] S_WA = 4'd0, S_WD = 4'd1, S_IA = 4'd2, S_ID = 4'd3, S_RS = 4'd4,
                         S_RE = 4'd5, S_RT = 4'd6, S_PS = 4'd7, S_PE = 4'd8, S_PT = 4'd9,
                         S_GO = 4'd10, S_Q = 4'd11, S_STEP = 4'd12, S_TR = 4'd13, S_ERR = 4'd14;
  state_t      state, state_n, fst;
  logic [2:0]  cmd, cmd_n, let_code;
  logic [31:0] acc, acc_n, data_n;
  logic        has_dig, has_n, dtype, dtype_n;
  logic [14:0] st, st_n;
  logic [3:0]  fs, nib;
  logic        is_dec, is_hex, is_del, is_term, is_q, is_s, is_t, is_let, busy, accept;
  assign is_dec  = rx_data >= 8'h30 && rx_data <= 8'h39;
  assign is_hex  = is_dec || (rx_data >= 8'h61 && rx_data <= 8'h66) || (rx_data >= 8'h41 && rx_data <= 8'h46);
  assign nib     = is_dec ? rx_data[3:0] : rx_data[3:0] + 4'd9;
  assign is_del  = rx_data == 8'h20;
  assign is_term = rx_data == 8'h0d || rx_data == 8'h0a;
  assign is_q    = rx_data == 8'h71;
  assign is_s    = rx_data == 8'h73;
  assign is_t    = rx_data == 8'h74;
  assign is_let  = rx_data == 8'h77 || rx_data == 8'h69 || rx_data == 8'h72 || rx_data == 8'h70 || rx_data == 8'h67;
  assign let_code = rx_data == 8'h77 ? C_W : rx_data == 8'h69 ? C_I : rx_data == 8'h72 ? C_R :
                    rx_data == 8'h70 ? C_P : C_G;
  assign busy    = dump_running | trush_running;
  assign accept  = rx_valid & (~busy | is_q);
  // strobe and follow-on state for a field close in the current argument state
  always_comb begin
    fs = S_GO;
    fst = SKIP;
    case (state)
      ARG1: begin
        fs  = cmd == C_W ? S_WA : cmd == C_I ? S_IA : cmd == C_R ? S_RS : cmd == C_P ? S_PS : S_GO;
        fst = (cmd == C_W || cmd == C_I) ? DATA : (cmd == C_R || cmd == C_P) ? ARG2 : SKIP;
      end
      ARG2: fs = cmd == C_P ? S_PE : S_RE;
      DATA: begin
        fs  = cmd == C_I ? S_ID : S_WD;
        fst = DATA;
      end
      default: ;
    endcase
  end
  always_comb begin
    state_n = state;
    cmd_n = cmd;
    acc_n = acc;
    has_n = has_dig;
    data_n = uart_data;
    dtype_n = dtype;
    st_n = '0;
    if (accept) begin
      acc_n = '0;
      has_n = 1'b0;
      if (is_q && (busy || state == IDLE || state == CMD)) begin
        st_n[S_Q]  = 1'b1;
        st_n[S_RT] = dump_running & ~dtype;
        st_n[S_PT] = dump_running & dtype;
        state_n = SKIP;
      end else begin
        case (state)
          IDLE, CMD: begin
            state_n = is_let ? ARG1 : (is_del | is_term) ? IDLE : SKIP;
            cmd_n = is_let ? let_code : cmd;
            st_n[S_STEP] = is_s;
            st_n[S_TR] = is_t;
            st_n[S_ERR] = ~(is_let | is_del | is_term | is_s | is_t);
          end
          SKIP: state_n = is_term ? IDLE : SKIP;
          default:
            if (is_hex) begin
              acc_n = {acc[27:0], nib};
              has_n = 1'b1;
            end else if (is_del | is_term) begin
              if (has_dig) begin
                data_n = acc;
                st_n[fs] = 1'b1;
                state_n = fst;
                dtype_n = state == ARG2 ? cmd == C_P : dtype;
              end
              if (is_term) state_n = IDLE;
            end else begin
              st_n[S_ERR] = 1'b1;
              state_n = SKIP;
            end
        endcase
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cmd <= C_W;
      acc <= '0;
      has_dig <= 1'b0;
      uart_data <= '0;
      dtype <= 1'b0;
      st <= '0;
    end else begin
      state <= state_n;
      cmd <= cmd_n;
      acc <= acc_n;
      has_dig <= has_n;
      uart_data <= data_n;
      dtype <= dtype_n;
      st <= st_n;
    end
  assign write_address_set = st[S_WA];
  assign write_data_en     = st[S_WD];
  assign inst_address_set  = st[S_IA];
  assign inst_data_en      = st[S_ID];
  assign read_start_set    = st[S_RS];
  assign read_end_set      = st[S_RE];
  assign read_stop         = st[S_RT];
  assign pgm_start_set     = st[S_PS];
  assign pgm_end_set       = st[S_PE];
  assign pgm_stop          = st[S_PT];
  assign cpu_start         = st[S_GO];
  assign quit_cmd          = st[S_Q];
  assign start_step        = st[S_STEP];
  assign start_trush       = st[S_TR];
  assign cmd_error         = st[S_ERR];
`ifdef UART_CMD_ECHO_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      echo_data <= '0;
      echo_valid <= 1'b0;
    end else begin
      echo_valid <= accept;
      if (accept) echo_data <= rx_data;
    end
`else
  assign echo_data = '0;
  assign echo_valid = 1'b0;
`endif
endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// tb_uart_cmd_ctrl: table of command lines with expected strobe/operand events, checked through a scoreboard queue.
module tb_uart_cmd_ctrl;
  logic clk = 0, rst_n = 0, rx_valid = 0, dump_running = 0, trush_running = 0;
  logic [7:0] rx_data = 0;
  logic [31:0] uart_data;
  logic write_address_set, write_data_en, inst_address_set, inst_data_en;
  logic read_start_set, read_end_set, read_stop, pgm_start_set, pgm_end_set, pgm_stop;
  logic cpu_start, quit_cmd, start_step, start_trush, cmd_error, echo_valid;
  logic [7:0] echo_data;
  always #5 clk = ~clk;
  uart_cmd_ctrl dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .dump_running(dump_running), .trush_running(trush_running), .uart_data(uart_data),
    .write_address_set(write_address_set), .write_data_en(write_data_en),
    .inst_address_set(inst_address_set), .inst_data_en(inst_data_en),
    .read_start_set(read_start_set), .read_end_set(read_end_set), .read_stop(read_stop),
    .pgm_start_set(pgm_start_set), .pgm_end_set(pgm_end_set), .pgm_stop(pgm_stop),
    .cpu_start(cpu_start), .quit_cmd(quit_cmd), .start_step(start_step),
    .start_trush(start_trush), .cmd_error(cmd_error), .echo_data(echo_data), .echo_valid(echo_valid)
  );
  wire [14:0] strb = {cmd_error, start_trush, start_step, quit_cmd, cpu_start, pgm_stop, pgm_end_set,
                      pgm_start_set, read_stop, read_end_set, read_start_set, inst_data_en,
                      inst_address_set, write_data_en, write_address_set};
  localparam logic [14:0] WA = 15'h0001, WD = 15'h0002, IA = 15'h0004, ID = 15'h0008, RS = 15'h0010,
                          RE = 15'h0020, RT = 15'h0040, PS = 15'h0080, PE = 15'h0100, PT = 15'h0200,
                          GO = 15'h0400, QC = 15'h0800, ST = 15'h1000, TR = 15'h2000, ER = 15'h4000;
  typedef struct { logic [14:0] m; logic [31:0] d; } ev_t;
  typedef struct {
    string s; bit dm; bit tr;
    logic [14:0] m0; logic [31:0] d0; logic [14:0] m1; logic [31:0] d1; logic [14:0] m2; logic [31:0] d2;
  } vec_t;
  vec_t vecs[$];
  ev_t exq[$];
  ev_t ev;
  int checks = 0, passes = 0;
  bit mon_en = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
  endtask
  function automatic void add(input string s, input bit dm, input bit tr,
                              input logic [14:0] m0 = '0, input logic [31:0] d0 = '0,
                              input logic [14:0] m1 = '0, input logic [31:0] d1 = '0,
                              input logic [14:0] m2 = '0, input logic [31:0] d2 = '0);
    vecs.push_back('{s, dm, tr, m0, d0, m1, d1, m2, d2});
  endfunction
  task automatic send(input string s);
    for (int i = 0; i < s.len(); i++) begin
      @(negedge clk);
      rx_data = s[i];
      rx_valid = 1;
    end
    @(negedge clk);
    rx_valid = 0;
  endtask
  always @(negedge clk)
    if (mon_en && rst_n && strb != '0) begin
      if (exq.size() == 0) chk("unexpected_strobe", 32'(strb), 32'd0);
      else begin
        ev = exq.pop_front();
        chk("strobe", 32'(strb), 32'(ev.m));
        chk("uart_data", uart_data, ev.d);
      end
    end
  initial begin
    add("w 100 DEADBEEF 1234\015", 0, 0, WA, 32'h100, WD, 32'hdeadbeef, WD, 32'h1234);
    add("r 0 3c\015", 0, 0, RS, 32'h0, RE, 32'h3c);
    add("x", 1, 0);
    add("q", 1, 0, QC | RT, 32'h3c);
    add("\015", 0, 0);
    add("p 0  40\n", 0, 0, PS, 32'h0, PE, 32'h40);
    add("q", 1, 0, QC | PT, 32'h40);
    add("\n", 0, 0);
    add("g 123456789\015", 0, 0, GO, 32'h23456789);
    add("z 5\015s\015", 0, 0, ER, 32'h23456789, ST, 32'h23456789);
    add("w 5\015", 0, 1);
    add("q\015", 0, 0, QC, 32'h23456789);
    add("w 1G\015", 0, 0, ER, 32'h23456789);
    add("r 5\015", 0, 0, RS, 32'h5);
    add("i 20 ab\015", 0, 0, IA, 32'h20, ID, 32'hab);
    add("5\015", 0, 0, ER, 32'hab);
    add("  \015", 0, 0);
    add("w 12", 0, 0);
    add("q", 0, 1, QC, 32'hab);
    add("3\015", 0, 0);
    add("g 7\015", 0, 0, GO, 32'h7);
    add("r 1 2 3\015", 0, 0, RS, 32'h1, RE, 32'h2);
    repeat (2) @(negedge clk);
    chk("reset_uart_data", uart_data, 32'h0);
    chk("reset_strobes", 32'(strb), 32'h0);
    chk("reset_echo_data", 32'(echo_data), 32'h0);
    chk("reset_echo_valid", 32'(echo_valid), 32'h0);
    rst_n = 1;
    mon_en = 1;
    foreach (vecs[k]) begin
      dump_running = vecs[k].dm;
      trush_running = vecs[k].tr;
      if (vecs[k].m0 != '0) exq.push_back('{vecs[k].m0, vecs[k].d0});
      if (vecs[k].m1 != '0) exq.push_back('{vecs[k].m1, vecs[k].d1});
      if (vecs[k].m2 != '0) exq.push_back('{vecs[k].m2, vecs[k].d2});
      send(vecs[k].s);
      repeat (3) @(negedge clk);
      chk($sformatf("pending_events_line_%0d", k), exq.size(), 0);
      dump_running = 0;
      trush_running = 0;
    end
    exq.push_back('{TR, 32'h2});
    @(negedge clk);
    rx_data = 8'h74;
    rx_valid = 1;
    @(negedge clk);
    rx_valid = 0;
`ifdef UART_CMD_ECHO_EN
    chk("echo_valid", 32'(echo_valid), 32'h1);
    chk("echo_data", 32'(echo_data), 32'h74);
`else
    chk("echo_valid", 32'(echo_valid), 32'h0);
    chk("echo_data", 32'(echo_data), 32'h0);
`endif
    send("\015");
    repeat (2) @(negedge clk);
    chk("pending_events_trush", exq.size(), 0);
    send("w 10");
    rst_n = 0;
    @(negedge clk);
    chk("midreset_uart_data", uart_data, 32'h0);
    chk("midreset_strobes", 32'(strb), 32'h0);
    @(negedge clk);
    rst_n = 1;
    exq.push_back('{GO, 32'h5});
    send("g 5\015");
    repeat (3) @(negedge clk);
    chk("pending_events_after_reset", exq.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
